// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central hazard/flow controller for the 5-stage core (IF, ID, EX, MEM, WB).
// Produces load-enable, hold and clear controls for the four inter-stage
// register slices and the PC hold/redirect select. It tracks multi-cycle MDU
// occupancy of EX and stale-fetch drops, and counts PC-stall cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used         ID source registers and their use flags
//   ex_is_load, ex_rd             EX load flag and destination register
//   ex_mdu_start                  one-cycle pulse: new mul/div entered EX
//   ex_redirect                   EX branch/jump mispredict
//   if_busy, mem_busy             fetch / LSU not ready this cycle
//   wb_trap                       WB raises exception or mret
//   pc_stall, pc_sel              PC hold; PC source (0 seq, 1 branch, 2 trap)
//   {ifid,idex,exmem,memwb}_en/_stall/_flush   slice controls
//   mdu_busy                      MDU occupancy counter nonzero
//   stall_cnt                     count of non-reset cycles with pc_stall=1
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mdu_start,
    input  logic              ex_redirect,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              wb_trap,
    output logic              pc_stall,
    output logic [1:0]        pc_sel,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              exmem_stall,
    output logic              memwb_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              mdu_busy,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        DROP = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MDU_RELOAD = CNT_W'(MDU_LAT - 1);
    localparam bit               MDU_MULTI  = (MDU_LAT > 1);

    state_t           state;
    logic [CNT_W-1:0] mdu_cnt;

    logic       load_use;
    logic       mdu_start_ok;
    logic       mdu_hold;
    logic       sel_mem;
    logic       sel_mdu;
    logic       sel_redir;
    logic       sel_lu;
    logic       sel_ifb;
    logic       drop_done;
    logic [3:0] en_v;     // [3] IF/ID, [2] ID/EX, [1] EX/MEM, [0] MEM/WB
    logic [3:0] stall_v;
    logic [3:0] flush_v;

    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // A start is only accepted when the MDU is idle; with a one-cycle MDU the
    // start cycle is also the final cycle, so nothing is held.
    assign mdu_start_ok = ex_mdu_start && (mdu_cnt == '0);
    assign mdu_hold     = (mdu_start_ok && MDU_MULTI) || (mdu_cnt > CNT_W'(1));

    // One-hot priority decode below the trap.
    assign sel_mem   = !wb_trap && mem_busy;
    assign sel_mdu   = !wb_trap && !mem_busy && mdu_hold;
    assign sel_redir = !wb_trap && !mem_busy && !mdu_hold && ex_redirect;
    assign sel_lu    = !wb_trap && !mem_busy && !mdu_hold && !ex_redirect && load_use;
    assign sel_ifb   = !wb_trap && !mem_busy && !mdu_hold && !ex_redirect && !load_use && if_busy;

    // The stale response arrives when fetch stops being busy in DROP.
    assign drop_done = (state == DROP) && !if_busy;

    always_comb begin
        en_v     = 4'b0000;
        stall_v  = 4'b0000;
        flush_v  = 4'b0000;
        pc_stall = 1'b0;
        pc_sel   = 2'd0;
        if (rst) begin
            flush_v  = 4'b1111;
            pc_stall = 1'b1;
        end else begin
            en_v = 4'b1111;
            if (wb_trap) begin
                flush_v = 4'b1111;
                pc_sel  = 2'd2;
            end else if (sel_mem) begin
                stall_v  = 4'b1110;
                flush_v  = 4'b0001;
                pc_stall = 1'b1;
            end else if (sel_mdu) begin
                stall_v  = 4'b1100;
                flush_v  = 4'b0010;
                pc_stall = 1'b1;
            end else if (sel_redir) begin
                flush_v = 4'b1100;
                pc_sel  = 2'd1;
            end else if (sel_lu) begin
                stall_v  = 4'b1000;
                flush_v  = 4'b0100;
                pc_stall = 1'b1;
            end else if (sel_ifb) begin
                flush_v  = 4'b1000;
                pc_stall = 1'b1;
            end
            // Discarding the stale fetch is never delayed; a hold on IF/ID
            // yields to the clear.
            if (drop_done) begin
                flush_v[3] = 1'b1;
                stall_v[3] = 1'b0;
            end
        end
    end

    assign {ifid_en, idex_en, exmem_en, memwb_en}             = en_v;
    assign {ifid_stall, idex_stall, exmem_stall, memwb_stall} = stall_v;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = flush_v;
    assign mdu_busy = (mdu_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mdu_cnt   <= '0;
            stall_cnt <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            // The counter runs down regardless of memory back-pressure.
            if (wb_trap) begin
                mdu_cnt <= '0;
            end else if (mdu_start_ok) begin
                mdu_cnt <= MDU_RELOAD;
            end else if (mdu_cnt != '0) begin
                mdu_cnt <= mdu_cnt - CNT_W'(1);
            end

            // A redirect or trap while a fetch is outstanding leaves a stale
            // response in flight that must be discarded when it lands.
            if ((wb_trap || sel_redir) && if_busy) begin
                state <= DROP;
            end else if (drop_done) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int LAT    = 12;
    localparam int CNT_W  = 6;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_rs1_used, id_rs2_used, ex_is_load;
    logic              ex_mdu_start, ex_redirect, if_busy, mem_busy, wb_trap;
    logic              pc_stall;
    logic [1:0]        pc_sel;
    logic              ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic              ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic              mdu_busy;
    logic [31:0]       stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_mdu_start(ex_mdu_start), .ex_redirect(ex_redirect),
        .if_busy(if_busy), .mem_busy(mem_busy), .wb_trap(wb_trap),
        .pc_stall(pc_stall), .pc_sel(pc_sel),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    // ---------------- reference model ----------------
    // Expected behaviour derived from the priority rules: pick the single
    // winning hazard cause, look up its slice action, then apply the
    // stale-fetch discard on top.
    bit          m_drop;
    int          m_cnt;
    logic [31:0] m_stall;
    int          kind;        // 0 none,1 trap,2 mem,3 mdu,4 redirect,5 load-use,6 fetch
    logic        lu, mdu_occ;
    logic [3:0]  e_en, e_stall, e_flush;
    logic [1:0]  e_pcsel;
    logic        e_pcstall;

    always_comb begin
        kind      = 0;
        e_en      = 4'b0000;
        e_stall   = 4'b0000;
        e_flush   = 4'b0000;
        e_pcsel   = 2'd0;
        e_pcstall = 1'b0;
        lu = ex_is_load && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        mdu_occ = (m_cnt == 0 && ex_mdu_start && LAT > 1) || m_cnt > 1;
        if (rst) begin
            e_flush   = 4'b1111;
            e_pcstall = 1'b1;
        end else begin
            e_en = 4'b1111;
            if (wb_trap)          kind = 1;
            else if (mem_busy)    kind = 2;
            else if (mdu_occ)     kind = 3;
            else if (ex_redirect) kind = 4;
            else if (lu)          kind = 5;
            else if (if_busy)     kind = 6;
            case (kind)
                1: begin e_flush = 4'b1111; e_pcsel = 2'd2; end
                2: begin e_stall = 4'b1110; e_flush = 4'b0001; e_pcstall = 1'b1; end
                3: begin e_stall = 4'b1100; e_flush = 4'b0010; e_pcstall = 1'b1; end
                4: begin e_flush = 4'b1100; e_pcsel = 2'd1; end
                5: begin e_stall = 4'b1000; e_flush = 4'b0100; e_pcstall = 1'b1; end
                6: begin e_flush = 4'b1000; e_pcstall = 1'b1; end
                default: ;
            endcase
            if (m_drop && !if_busy) begin
                e_flush[3] = 1'b1;
                e_stall[3] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_drop  <= 1'b0;
            m_cnt   <= 0;
            m_stall <= 32'd0;
        end else begin
            m_stall <= m_stall + {31'd0, e_pcstall};
            if (kind == 1)                        m_cnt <= 0;
            else if (m_cnt == 0 && ex_mdu_start)  m_cnt <= LAT - 1;
            else if (m_cnt > 0)                   m_cnt <= m_cnt - 1;
            if ((kind == 1 || kind == 4) && if_busy) m_drop <= 1'b1;
            else if (!if_busy)                       m_drop <= 1'b0;
        end
    end

    logic [16:0] dvec, evec;
    assign dvec = {pc_stall, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_stall, idex_stall, exmem_stall, memwb_stall,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy};
    assign evec = {e_pcstall, e_pcsel, e_en, e_stall, e_flush, (m_cnt != 0)};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are changed just after a rising edge and held across the next.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic evaluate(input string tag);
        #1;
        check({tag, ".ctrl"}, 64'(dvec), 64'(evec));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    endtask

    task automatic clr();
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
        ex_mdu_start = 1'b0; ex_redirect = 1'b0; if_busy = 1'b0;
        mem_busy = 1'b0; wb_trap = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        evaluate("rst");
        cyc();
        evaluate("rst");
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int idex_stalls;
        logic [31:0] sc0;
        clr();
        rst = 1'b1;
        cyc();
        // reset state
        evaluate("reset");
        check("reset.flush", 64'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 64'hF);
        check("reset.en", 64'({ifid_en, idex_en, exmem_en, memwb_en}), 64'h0);
        check("reset.pc_stall", 64'(pc_stall), 64'd1);
        cyc();
        check("reset.stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // load-use, then same with ex_rd = 0
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        evaluate("lu");
        check("lu.stall", 64'({ifid_stall, idex_flush, pc_stall}), 64'b111);
        cyc();
        ex_rd = 5'd0; id_rs1 = 5'd0;
        evaluate("lu_x0");
        check("lu_x0.pc_stall", 64'(pc_stall), 64'd0);
        cyc();
        clr();

        // MDU occupancy
        sc0 = stall_cnt;
        idex_stalls = 0;
        ex_mdu_start = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            evaluate("mdu");
            if (idex_stall) idex_stalls++;
            cyc();
            ex_mdu_start = 1'b0;
        end
        check("mdu.stall_cycles", 64'(idex_stalls), 64'(LAT - 1));
        check("mdu.stall_cnt_delta", 64'(stall_cnt - sc0), 64'(LAT - 1));
        evaluate("mdu_done");
        check("mdu_done.busy", 64'(mdu_busy), 64'd0);

        // mem_busy masks a held redirect
        mem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            evaluate("memb");
            check("memb.pc_sel", 64'(pc_sel), 64'd0);
            cyc();
        end
        mem_busy = 1'b0;
        evaluate("memb_after");
        check("memb_after.redir", 64'({pc_sel, ifid_flush, idex_flush}), 64'b0111);
        cyc();
        clr();

        // redirect while fetch busy -> stale drop
        ex_redirect = 1'b1; if_busy = 1'b1;
        evaluate("drop0");
        cyc();
        ex_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            evaluate("drop_wait");
            cyc();
        end
        if_busy = 1'b0;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1;
        evaluate("drop_hit");
        check("drop_hit.ifid", 64'({ifid_flush, ifid_stall, idex_flush}), 64'b101);
        cyc();
        clr();
        evaluate("drop_idle");
        check("drop_idle.ifid_flush", 64'(ifid_flush), 64'd0);
        cyc();

        // trap with MDU counter at 10
        ex_mdu_start = 1'b1;
        evaluate("trap_m0");
        cyc();
        ex_mdu_start = 1'b0;
        evaluate("trap_m1");
        cyc();
        wb_trap = 1'b1;
        evaluate("trap");
        check("trap.flush_sel", 64'({ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel}), 64'b111110);
        cyc();
        wb_trap = 1'b0;
        evaluate("trap_after");
        check("trap_after.mdu_busy", 64'(mdu_busy), 64'd0);
        cyc();

        // reset mid-MDU with a drop pending
        ex_redirect = 1'b1; if_busy = 1'b1;
        evaluate("rmid0");
        cyc();
        ex_redirect = 1'b0; ex_mdu_start = 1'b1;
        evaluate("rmid1");
        cyc();
        ex_mdu_start = 1'b0;
        rst = 1'b1;
        evaluate("rmid_rst");
        check("rmid_rst.flush_en", 64'({ifid_flush, idex_flush, exmem_flush, memwb_flush,
                                         ifid_en, idex_en, exmem_en, memwb_en}), 64'hF0);
        cyc();
        rst = 1'b0; if_busy = 1'b0;
        evaluate("rmid_after");
        check("rmid_after.state", 64'({mdu_busy, ifid_flush}), 64'd0);
        check("rmid_after.stall_cnt", 64'(stall_cnt), 64'd0);
        cyc();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(99) < 2);
            wb_trap      = ($urandom_range(99) < 4);
            mem_busy     = ($urandom_range(99) < 15);
            ex_mdu_start = ($urandom_range(99) < 8);
            ex_redirect  = ($urandom_range(99) < 12);
            if_busy      = ($urandom_range(99) < 35);
            ex_is_load   = ($urandom_range(99) < 40);
            id_rs1_used  = $urandom_range(1);
            id_rs2_used  = $urandom_range(1);
            ex_rd        = REG_AW'($urandom_range(3));
            id_rs1       = REG_AW'($urandom_range(3));
            id_rs2       = REG_AW'($urandom_range(3));
            evaluate("rand");
            cyc();
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). It generates the en/stall/flush controls consumed by the four inter-stage register slices (IF/ID, ID/EX, EX/MEM, MEM/WB), plus PC hold/redirect controls. It tracks multi-cycle MDU occupancy and stale-fetch drops with internal state, and keeps a stall-cycle performance counter.

Parameters:
MDU_LAT, 32, cycles EX is occupied by a mul/div op (>=1)
CNT_W, 6, width of MDU occupancy counter; must hold MDU_LAT
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1  in  REG_AW  ID source reg 1
id_rs2  in  REG_AW  ID source reg 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
ex_is_load  in  1  EX holds a load
ex_rd  in  REG_AW  EX destination reg
ex_mdu_start  in  1  EX instruction is a new mul/div (one-cycle pulse)
ex_redirect  in  1  EX branch/jump mispredict
if_busy  in  1  fetch response not ready this cycle
mem_busy  in  1  LSU not ready this cycle
wb_trap  in  1  WB raises exception/mret
pc_stall  out  1  hold PC
pc_sel  out  2  0 seq, 1 branch target, 2 trap vector
{ifid,idex,exmem,memwb}_en  out  1 each  slice load enable
{ifid,idex,exmem,memwb}_stall  out  1 each  slice hold
{ifid,idex,exmem,memwb}_flush  out  1 each  slice clear
mdu_busy  out  1  MDU counter nonzero
stall_cnt  out  32  cycles with pc_stall=1

Behaviour:
- State: FSM {IDLE, DROP}; mdu_cnt[CNT_W]; stall_cnt. All registered.
- Reset (rst=1): FSM=IDLE, mdu_cnt=0, stall_cnt=0. While rst=1 outputs: all *_flush=1, *_stall=0, *_en=0, pc_stall=1, pc_sel=0. stall_cnt does not count reset cycles.
- Outside reset, all *_en=1. Outputs are combinational from state+inputs, priority highest first:
- P1 wb_trap: flush all four slices, pc_sel=2, pc_stall=0, mdu_cnt<=0. If if_busy, FSM<=DROP.
- P2 mem_busy: stall IF/ID, ID/EX, EX/MEM; flush MEM/WB; pc_stall=1. ex_redirect ignored (EX re-asserts it later). mdu_cnt keeps counting down.
- P3 MDU occupancy (ex_mdu_start with mdu_cnt==0, or mdu_cnt>1): stall IF/ID, ID/EX; flush EX/MEM; pc_stall=1. On start mdu_cnt<=MDU_LAT-1; else decrement. mdu_cnt==1 is the final cycle: EX advances normally. MDU_LAT=1 means no stall. ex_redirect ignored while stalled.
- P4 ex_redirect: flush IF/ID, ID/EX; pc_sel=1; pc_stall=0. Overrides load-use. If if_busy, FSM<=DROP.
- P5 load-use (ex_is_load && ex_rd!=0 && ((id_rs1_used&&id_rs1==ex_rd)||(id_rs2_used&&id_rs2==ex_rd))): stall IF/ID, flush ID/EX, pc_stall=1.
- P6 if_busy: flush IF/ID (bubble), pc_stall=1.
- DROP state: when if_busy=0 the returning stale instruction is discarded: flush IF/ID, FSM<=IDLE; lower-priority controls merge as usual (stall of IF/ID yields to flush). Higher-priority stalls (P2/P3) do not delay the drop. New redirect/trap during DROP with if_busy=1 stays in DROP.
- Stall and flush never both 1 for one slice; flush wins.
- mdu_busy = (mdu_cnt!=0).
- stall_cnt increments each non-reset cycle with pc_stall=1; wraps at 2^32-1 -> 0.
- Reset mid-MDU or mid-DROP: immediate return to IDLE/0 next cycle.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> ifid_stall=1, idex_flush=1, pc_stall=1; ex_rd=0 same case -> no stall.
- MDU: MDU_LAT=4, ex_mdu_start pulse -> 3 cycles idex_stall=1/exmem_flush=1, mdu_busy high 3 cycles, 4th cycle all advance; stall_cnt +=3.
- mem_busy 2 cycles with ex_redirect=1 held -> no pc_sel=1 during busy; cycle after -> pc_sel=1, ifid_flush=idex_flush=1.
- Redirect with if_busy=1 -> FSM DROP; if_busy 2 more cycles then 0 -> that cycle ifid_flush=1, FSM IDLE next.
- wb_trap during MDU (mdu_cnt=10) -> all four flush=1, pc_sel=2, mdu_busy=0 next cycle.
- rst asserted mid-MDU with DROP pending -> next cycle mdu_cnt=0, IDLE, stall_cnt=0; during rst all flush=1, en=0.
